la_capture_ctrl: RTL and testbench

Sample-capture controller for the logic analyzer. It samples the probe bus at a programmable rate and writes the samples into the capture RAM through its write port (`we`, `addr`, `din`). Writes wrap around the RAM as a circular buffer. It watches for a programmable trigger, keeps a programmable number of pre-trigger samples, and stops once the buffer holds the post-trigger samples. It reports `start_addr` so the VGA display stage reads the buffer in time order starting from the oldest kept sample.

---
 rtl/la_capture_ctrl.sv | 140 ++++++++++++++
 tb/tb_la_capture_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/la_capture_ctrl.sv
// Logic-analyzer capture controller: samples the probe bus at a programmable rate into a
// circular capture RAM, keeps pre_count samples before the trigger and fills the rest after it.
module la_capture_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          arm,
  input  logic [DATA_WIDTH-1:0]         probe_in,
  input  logic [$clog2(DATA_WIDTH)-1:0] trig_ch,
  input  logic [1:0]                    trig_mode,
  input  logic [DIV_WIDTH-1:0]          rate_div,
  input  logic [ADDR_WIDTH-1:0]         pre_count,
  output logic                          we,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic [DATA_WIDTH-1:0]         din,
  output logic [ADDR_WIDTH-1:0]         start_addr,
  output logic                          busy,
  output logic                          triggered,
  output logic                          done
);

  localparam int CH_WIDTH = $clog2(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_e;
  typedef enum logic [1:0] {M_RISE, M_FALL, M_HIGH, M_LOW} trig_mode_e;

  state_e                  state_q, state_d;
  trig_mode_e              mode_q;
  logic [CH_WIDTH-1:0]     ch_q;
  logic [DIV_WIDTH-1:0]    div_max_q, div_q;
  logic [ADDR_WIDTH-1:0]   pre_q, wr_ptr_q;
  logic [ADDR_WIDTH:0]     cnt_q;
  logic [DATA_WIDTH-1:0]   prev_q;
  logic                    prev_valid_q, trig_q;

  logic [ADDR_WIDTH:0]     post_target;
  logic                    active, post_full, tick, pre_last, cur_bit, prev_bit, hit;

  // A POST phase that has written all its samples stops ticking while it drains into DONE.
  assign post_target = DEPTH - {1'b0, pre_q};
  assign active      = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign post_full   = (state_q == S_POST) && (cnt_q == post_target);
  assign tick        = active && !post_full && !arm && (div_q == div_max_q);
  assign pre_last    = (cnt_q + (ADDR_WIDTH + 1)'(1)) == {1'b0, pre_q};
  assign cur_bit     = probe_in[ch_q];
  assign prev_bit    = prev_q[ch_q];

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    hit = 1'b0;
    case (mode_q)
      M_RISE: hit = prev_valid_q && !prev_bit && cur_bit;
      M_FALL: hit = prev_valid_q && prev_bit && !cur_bit;
      M_HIGH: hit = cur_bit;
      M_LOW:  hit = !cur_bit;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = (pre_count != '0) ? S_PRE : S_WAIT;
    end else begin
      case (state_q)
        S_PRE:   if (tick && pre_last) state_d = S_WAIT;
        S_WAIT:  if (tick && hit) state_d = S_POST;
        S_POST:  if (post_full) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q       <= M_RISE;
      ch_q         <= '0;
      div_max_q    <= '0;
      pre_q        <= '0;
      div_q        <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      trig_q       <= 1'b0;
      we           <= 1'b0;
      addr         <= '0;
      din          <= '0;
      start_addr   <= '0;
    end else begin
      we <= tick;
      if (arm) begin
        mode_q       <= trig_mode_e'(trig_mode);
        ch_q         <= trig_ch;
        div_max_q    <= rate_div;
        pre_q        <= pre_count;
        div_q        <= '0;
        wr_ptr_q     <= '0;
        cnt_q        <= '0;
        prev_valid_q <= 1'b0;
        trig_q       <= 1'b0;
      end else begin
        if (active) div_q <= (div_q == div_max_q) ? '0 : div_q + DIV_WIDTH'(1);
        if (tick) begin
          addr         <= wr_ptr_q;
          din          <= probe_in;
          wr_ptr_q     <= wr_ptr_q + ADDR_WIDTH'(1);
          prev_q       <= probe_in;
          prev_valid_q <= 1'b1;
          case (state_q)
            S_PRE:  cnt_q <= pre_last ? '0 : cnt_q + (ADDR_WIDTH + 1)'(1);
            S_WAIT: if (hit) begin
              // The hit sample is post sample #1; the oldest kept sample sits pre_count before it.
              trig_q     <= 1'b1;
              start_addr <= wr_ptr_q - pre_q;
              cnt_q      <= (ADDR_WIDTH + 1)'(1);
            end
            S_POST: cnt_q <= cnt_q + (ADDR_WIDTH + 1)'(1);
            default: cnt_q <= cnt_q;
          endcase
        end
      end
    end
  end

  assign busy      = active;
  assign triggered = trig_q;
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Bench for la_capture_ctrl (N = 16): hand-derived capture table, random captures against a
// sample-index reference model, re-arm during POST and asynchronous reset during WAIT.
module tb_la_capture_ctrl;

  localparam int AW = 4, DW = 8, VW = 16, N = 16;
  localparam int SEQ_LEN = 1024, MAX_SAMPLES = 200;

  logic          clk = 1'b0, reset, arm;
  logic [DW-1:0] probe_in;
  logic [2:0]    trig_ch;
  logic [1:0]    trig_mode;
  logic [VW-1:0] rate_div;
  logic [AW-1:0] pre_count;
  logic          we, busy, triggered, done;
  logic [AW-1:0] addr, start_addr;
  logic [DW-1:0] din;

  la_capture_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .probe_in(probe_in), .trig_ch(trig_ch),
    .trig_mode(trig_mode), .rate_div(rate_div), .pre_count(pre_count), .we(we), .addr(addr),
    .din(din), .start_addr(start_addr), .busy(busy), .triggered(triggered), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  // probe_seq[c] is the probe value seen at the c-th clock edge after the arm edge.
  logic [DW-1:0] probe_seq [SEQ_LEN];

  typedef struct {
    int rd, pre, ch, mode, lo, hi, sw, exp_trig, exp_writes, exp_start;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Sample j of a capture is taken at edge (rd+1)*(j+1); returns first trigger sample or -1.
  function automatic int find_hit(input int rd, input int pre, input int ch, input int mode);
    logic [DW-1:0] cur, prv;
    logic hit;
    for (int j = pre; j < MAX_SAMPLES; j++) begin
      cur = probe_seq[(rd + 1) * (j + 1)];
      prv = (j > 0) ? probe_seq[(rd + 1) * j] : '0;
      case (mode)
        0:       hit = (j > 0) && !prv[ch] && cur[ch];
        1:       hit = (j > 0) && prv[ch] && !cur[ch];
        2:       hit = cur[ch];
        default: hit = !cur[ch];
      endcase
      if (hit) return j;
    end
    return -1;
  endfunction

  task automatic fill_steps(input int lo, input int hi, input int sw);
    for (int c = 0; c < SEQ_LEN; c++) probe_seq[c] = (c < sw) ? DW'(lo) : DW'(hi);
  endtask

  task automatic run_capture(input int rd, input int pre, input int ch, input int mode,
                             input int abort_at, input int idle_len, output int n_writes);
    int h, total, done_c, len, j;
    logic exp_we, exp_trig, exp_done;
    h      = find_hit(rd, pre, ch, mode);
    total  = (h >= 0) ? h + N - pre : 0;
    done_c = (h >= 0) ? (rd + 1) * total + 1 : 0;
    len    = (h >= 0) ? done_c + 2 : idle_len;
    if (abort_at > 0 && abort_at < len) len = abort_at;
    trig_ch = 3'(ch); trig_mode = 2'(mode); rate_div = VW'(rd); pre_count = AW'(pre);
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    trig_ch = 3'($urandom); trig_mode = 2'($urandom);
    rate_div = VW'($urandom); pre_count = AW'($urandom);
    check("after_arm {we,busy,trig,done}", {we, busy, triggered, done}, 4'b0100);
    n_writes = 0;
    for (int c = 1; c <= len; c++) begin
      probe_in = probe_seq[c];
      @(posedge clk); #1;
      j        = c / (rd + 1) - 1;
      exp_we   = (c % (rd + 1) == 0) && (h < 0 || j < total);
      exp_trig = (h >= 0) && (c >= (rd + 1) * (h + 1));
      exp_done = (h >= 0) && (c >= done_c);
      check($sformatf("status c=%0d {we,busy,trig,done}", c), {we, busy, triggered, done},
            {exp_we, !exp_done, exp_trig, exp_done});
      if (exp_we) begin
        check($sformatf("addr c=%0d", c), 32'(addr), 32'(j % N));
        check($sformatf("din c=%0d", c), 32'(din), 32'(probe_seq[c]));
      end
      if (exp_done) check("start_addr", 32'(start_addr), 32'((((h - pre) % N) + N) % N));
      if (we) n_writes++;
    end
  endtask

  initial begin
    int nw, h, rd, pre, ch, mode;
    reset = 1'b0; arm = 1'b0; probe_in = '0;
    trig_ch = '0; trig_mode = '0; rate_div = '0; pre_count = '0;
    #1 reset = 1'b1;
    #1 check("reset outputs", {we, addr, din, start_addr, busy, triggered, done}, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("idle {we,busy,trig,done}", {we, busy, triggered, done}, 4'b0000);

    //          rd pre ch mode lo     hi     sw  trig writes start
    vecs[0] = '{0, 4,  0, 0,   'h00, 'h01, 11, 1,   22,    6};  // rising, pre-trigger
    vecs[1] = '{0, 0,  2, 2,   'h04, 'h04, 0,  1,   16,    0};  // level high, already high
    vecs[2] = '{3, 2,  5, 1,   'h20, 'h00, 21, 1,   19,    3};  // divider 4, falling
    vecs[3] = '{1, 15, 7, 3,   'h00, 'h00, 0,  1,   16,    0};  // max pre, level low
    vecs[4] = '{0, 0,  3, 1,   'h55, 'h55, 0,  0,   40,    0};  // edge mask, never fires
    vecs[5] = '{2, 8,  4, 0,   'h00, 'h10, 91, 1,   38,    6};  // WAIT wraps before hit

    for (int v = 0; v < 6; v++) begin
      fill_steps(vecs[v].lo, vecs[v].hi, vecs[v].sw);
      run_capture(vecs[v].rd, vecs[v].pre, vecs[v].ch, vecs[v].mode, 0, 40, nw);
      check($sformatf("vec%0d writes", v), 32'(nw), 32'(vecs[v].exp_writes));
      check($sformatf("vec%0d triggered", v), 32'(triggered), 32'(vecs[v].exp_trig));
      if (vecs[v].exp_trig != 0)
        check($sformatf("vec%0d start_addr", v), 32'(start_addr), 32'(vecs[v].exp_start));
    end

    // Re-arm mid-POST on a tick cycle, then complete a capture with a different configuration.
    fill_steps(vecs[0].lo, vecs[0].hi, vecs[0].sw);
    run_capture(vecs[0].rd, vecs[0].pre, vecs[0].ch, vecs[0].mode, 15, 40, nw);
    fill_steps(vecs[2].lo, vecs[2].hi, vecs[2].sw);
    run_capture(vecs[2].rd, vecs[2].pre, vecs[2].ch, vecs[2].mode, 0, 40, nw);
    check("rearm writes", 32'(nw), 32'(vecs[2].exp_writes));
    check("rearm start_addr", 32'(start_addr), 32'(vecs[2].exp_start));

    for (int r = 0; r < 12; r++) begin
      rd   = $urandom_range(0, 3);
      pre  = $urandom_range(0, N - 1);
      ch   = $urandom_range(0, DW - 1);
      mode = $urandom_range(0, 3);
      for (int c = 0; c < SEQ_LEN; c++) probe_seq[c] = DW'($urandom);
      h = find_hit(rd, pre, ch, mode);
      run_capture(rd, pre, ch, mode, 0, 40, nw);
      if (h >= 0) check($sformatf("rand%0d writes", r), 32'(nw), 32'(h + N - pre));
      else        check($sformatf("rand%0d writes", r), 32'(nw), 32'(40 / (rd + 1)));
    end

    // Asynchronous reset in the middle of a WAIT phase.
    fill_steps(vecs[4].lo, vecs[4].hi, vecs[4].sw);
    run_capture(vecs[4].rd, vecs[4].pre, vecs[4].ch, vecs[4].mode, 20, 40, nw);
    #2 reset = 1'b1;
    #1 check("reset mid-WAIT outputs", {we, addr, din, start_addr, busy, triggered, done}, '0);
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      probe_in = DW'($urandom);
      @(posedge clk); #1;
      check($sformatf("post-reset c=%0d {we,busy}", c), {we, busy}, 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
